dhvajanka_reconstruct: RTL and testbench



---
 rtl/dhvajanka_reconstruct.sv | 159 +++++++++++++++
 tb/tb_dhvajanka_reconstruct.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dhvajanka_reconstruct.sv
// Rebuilds dividend = quotient*divisor + remainder with a radix-2 shift-add multiplier.
// Optional macro DHVAJANKA_RECON_CHECK_EN adds expected_dividend input and match output.
module dhvajanka_reconstruct #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     quotient,
    input  logic [WIDTH-1:0]     divisor,
    input  logic [WIDTH-1:0]     remainder,
`ifdef DHVAJANKA_RECON_CHECK_EN
    input  logic [WIDTH-1:0]     expected_dividend,
    output logic                 match,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 fits_width,
    output logic                 rem_err,
    output logic                 div_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_ADD,
        S_DONE
    } state_t;

    state_t               state, state_n;
    logic [2*WIDTH-1:0]   acc, acc_n;
    logic [2*WIDTH-1:0]   mcand, mcand_n;
    logic [WIDTH-1:0]     mplier, mplier_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [WIDTH-1:0]     div_q, div_q_n;
    logic [WIDTH-1:0]     rem_q, rem_q_n;
    logic [2*WIDTH-1:0]   sum;
    logic                 busy_n, done_n;
    logic [2*WIDTH-1:0]   result_n;
    logic                 fits_n, rem_err_n, div_zero_n;
`ifdef DHVAJANKA_RECON_CHECK_EN
    logic [WIDTH-1:0]     exp_q, exp_q_n;
    logic                 match_n;
`endif

    assign sum = acc + {{WIDTH{1'b0}}, rem_q};

    always_comb begin
        state_n    = state;
        acc_n      = acc;
        mcand_n    = mcand;
        mplier_n   = mplier;
        cnt_n      = cnt;
        div_q_n    = div_q;
        rem_q_n    = rem_q;
        busy_n     = busy;
        done_n     = done;
        result_n   = result;
        fits_n     = fits_width;
        rem_err_n  = rem_err;
        div_zero_n = div_zero;
`ifdef DHVAJANKA_RECON_CHECK_EN
        exp_q_n    = exp_q;
        match_n    = match;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    acc_n    = '0;
                    mcand_n  = {{WIDTH{1'b0}}, divisor};
                    mplier_n = quotient;
                    cnt_n    = '0;
                    div_q_n  = divisor;
                    rem_q_n  = remainder;
`ifdef DHVAJANKA_RECON_CHECK_EN
                    exp_q_n  = expected_dividend;
`endif
                    busy_n   = 1'b1;
                    state_n  = S_MUL;
                end
            end
            S_MUL: begin
                if (mplier[0]) begin
                    acc_n = acc + mcand;
                end
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                cnt_n    = cnt + CW'(1);
                // Fixed WIDTH iterations regardless of remaining multiplier bits.
                if (cnt == CW'(WIDTH - 1)) begin
                    state_n = S_ADD;
                end
            end
            S_ADD: begin
                result_n   = sum;
                fits_n     = (sum[2*WIDTH-1:WIDTH] == '0);
                rem_err_n  = (rem_q >= div_q);
                div_zero_n = (div_q == '0);
`ifdef DHVAJANKA_RECON_CHECK_EN
                match_n    = fits_n && (sum[WIDTH-1:0] == exp_q) && !rem_err_n;
`endif
                done_n     = 1'b1;
                state_n    = S_DONE;
            end
            S_DONE: begin
                done_n  = 1'b0;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
            div_q      <= '0;
            rem_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            fits_width <= 1'b0;
            rem_err    <= 1'b0;
            div_zero   <= 1'b0;
`ifdef DHVAJANKA_RECON_CHECK_EN
            exp_q      <= '0;
            match      <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            acc        <= acc_n;
            mcand      <= mcand_n;
            mplier     <= mplier_n;
            cnt        <= cnt_n;
            div_q      <= div_q_n;
            rem_q      <= rem_q_n;
            busy       <= busy_n;
            done       <= done_n;
            result     <= result_n;
            fits_width <= fits_n;
            rem_err    <= rem_err_n;
            div_zero   <= div_zero_n;
`ifdef DHVAJANKA_RECON_CHECK_EN
            exp_q      <= exp_q_n;
            match      <= match_n;
`endif
        end
    end

endmodule

// File: tb/tb_dhvajanka_reconstruct.sv
// Directed self-checking bench for dhvajanka_reconstruct (WIDTH=16).
module tb_dhvajanka_reconstruct;

    localparam int unsigned W = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [W-1:0]    quotient = '0;
    logic [W-1:0]    divisor = '0;
    logic [W-1:0]    remainder = '0;
    logic            busy, done, fits_width, rem_err, div_zero;
    logic [2*W-1:0]  result;
`ifdef DHVAJANKA_RECON_CHECK_EN
    logic [W-1:0]    expected_dividend = '0;
    logic            match;
`endif

    int n_cmp = 0;
    int n_err = 0;

    dhvajanka_reconstruct #(.WIDTH(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .quotient          (quotient),
        .divisor           (divisor),
        .remainder         (remainder),
`ifdef DHVAJANKA_RECON_CHECK_EN
        .expected_dividend (expected_dividend),
        .match             (match),
`endif
        .busy              (busy),
        .done              (done),
        .result            (result),
        .fits_width        (fits_width),
        .rem_err           (rem_err),
        .div_zero          (div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one operation and returns the outputs seen in the done cycle.
    task automatic run_op(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r,
                          output logic [2*W-1:0] res, output logic fw, output logic re,
                          output logic dz, output int lat, output logic timeout);
        quotient = q; divisor = d; remainder = r; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        timeout = !done;
        res = result; fw = fits_width; re = rem_err; dz = div_zero;
        for (int i = 0; i < 10 && busy; i++) tick();
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({busy, done, fits_width, rem_err, div_zero} !== 5'b0 || result !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got busy=%b done=%b res=%0d fw=%b re=%b dz=%b required all 0",
                     busy, done, result, fits_width, rem_err, div_zero);
        end
`ifdef DHVAJANKA_RECON_CHECK_EN
        n_cmp++;
        if (match !== 1'b0) begin
            n_err++;
            $display("FAIL reset_match got %b required 0", match);
        end
`endif
    endtask

    task automatic test_basic();
        int cyc, done_at, done_cnt, busy_cnt;
        logic [2*W-1:0] held;
        quotient = 16'd123; divisor = 16'd98; remainder = 16'd45; start = 1'b1;
`ifdef DHVAJANKA_RECON_CHECK_EN
        expected_dividend = 16'd12099;
`endif
        tick();
        start = 1'b0;
        cyc = 0; done_at = -1; done_cnt = 0;
        busy_cnt = busy ? 1 : 0;
        while (busy && cyc < 40) begin
            tick();
            cyc++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = cyc;
                    n_cmp++;
                    if (result !== 32'd12099 || fits_width !== 1'b1 || rem_err !== 1'b0 || div_zero !== 1'b0) begin
                        n_err++;
                        $display("FAIL basic_result got res=%0d fw=%b re=%b dz=%b required 12099 1 0 0",
                                 result, fits_width, rem_err, div_zero);
                    end
`ifdef DHVAJANKA_RECON_CHECK_EN
                    n_cmp++;
                    if (match !== 1'b1) begin
                        n_err++;
                        $display("FAIL basic_match got %b required 1", match);
                    end
`endif
                end
            end
        end
        n_cmp++;
        if (done_at != 17) begin
            n_err++;
            $display("FAIL basic_latency got %0d required 17", done_at);
        end
        n_cmp++;
        if (busy_cnt != 18) begin
            n_err++;
            $display("FAIL basic_busy_cycles got %0d required 18", busy_cnt);
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL basic_done_pulses got %0d required 1", done_cnt);
        end
        // Result must hold while idle inputs wander.
        held = result;
        quotient = 16'hAAAA; divisor = 16'h5555; remainder = 16'h1234;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (result !== 32'd12099 || held !== 32'd12099) begin
            n_err++;
            $display("FAIL basic_hold got %0d required 12099", result);
        end
    endtask

    task automatic test_max();
        logic [2*W-1:0] res; logic fw, re, dz, to; int lat;
        run_op(16'hFFFF, 16'hFFFF, 16'hFFFE, res, fw, re, dz, lat, to);
        n_cmp++;
        if (to || res !== 32'hFFFEFFFF || fw !== 1'b0 || re !== 1'b0 || dz !== 1'b0) begin
            n_err++;
            $display("FAIL max_operands got to=%b res=%h fw=%b re=%b dz=%b required 0 fffeffff 0 0 0",
                     to, res, fw, re, dz);
        end
    endtask

    task automatic test_invalid();
        logic [2*W-1:0] res; logic fw, re, dz, to; int lat;
        run_op(16'd7, 16'd0, 16'd5, res, fw, re, dz, lat, to);
        n_cmp++;
        if (to || res !== 32'd5 || fw !== 1'b1 || re !== 1'b1 || dz !== 1'b1) begin
            n_err++;
            $display("FAIL div_zero got to=%b res=%0d fw=%b re=%b dz=%b required 0 5 1 1 1",
                     to, res, fw, re, dz);
        end
`ifdef DHVAJANKA_RECON_CHECK_EN
        expected_dividend = 16'd397;
`endif
        run_op(16'd3, 16'd99, 16'd100, res, fw, re, dz, lat, to);
        n_cmp++;
        if (to || res !== 32'd397 || re !== 1'b1 || dz !== 1'b0) begin
            n_err++;
            $display("FAIL rem_err got to=%b res=%0d re=%b dz=%b required 0 397 1 0", to, res, re, dz);
        end
`ifdef DHVAJANKA_RECON_CHECK_EN
        n_cmp++;
        if (match !== 1'b0) begin
            n_err++;
            $display("FAIL rem_err_match got %b required 0", match);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int first_at, second_at, done_cnt;
        logic [2*W-1:0] r1, r2;
        first_at = -1; second_at = -1; done_cnt = 0; r1 = '0; r2 = '0;
        quotient = 16'd10; divisor = 16'd10; remainder = 16'd3; start = 1'b1;
        tick();
        // Operands set after edge j are what an accept at edge j+1 would see.
        for (int j = 0; j < 42; j++) begin
            quotient = 16'(j); divisor = 16'd2; remainder = 16'd1;
            tick();
            if (done) begin
                done_cnt++;
                if (first_at < 0) begin first_at = j + 1; r1 = result; end
                else if (second_at < 0) begin second_at = j + 1; r2 = result; end
            end
        end
        start = 1'b0;
        for (int i = 0; i < 60 && busy; i++) tick();
        n_cmp++;
        if (first_at != 17 || r1 !== 32'd103) begin
            n_err++;
            $display("FAIL b2b_first got at=%0d res=%0d required 17 103", first_at, r1);
        end
        n_cmp++;
        if (second_at != 36 || r2 !== 32'd37) begin
            n_err++;
            $display("FAIL b2b_second got at=%0d res=%0d required 36 37", second_at, r2);
        end
        n_cmp++;
        if (done_cnt != 2) begin
            n_err++;
            $display("FAIL b2b_done_count got %0d required 2", done_cnt);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain got busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [2*W-1:0] res; logic fw, re, dz, to; int lat, done_cnt;
        quotient = 16'd5; divisor = 16'd6; remainder = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, fits_width, rem_err, div_zero} !== 5'b0 || result !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs got busy=%b done=%b res=%0d fw=%b re=%b dz=%b required all 0",
                     busy, done, result, fits_width, rem_err, div_zero);
        end
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        n_cmp++;
        if (done_cnt != 0) begin
            n_err++;
            $display("FAIL midreset_abandon got %0d active cycles required 0", done_cnt);
        end
        run_op(16'd2, 16'd3, 16'd1, res, fw, re, dz, lat, to);
        n_cmp++;
        if (to || res !== 32'd7 || lat != 17) begin
            n_err++;
            $display("FAIL midreset_after got to=%b res=%0d lat=%0d required 0 7 17", to, res, lat);
        end
    endtask

`ifdef DHVAJANKA_RECON_CHECK_EN
    task automatic test_check();
        logic [2*W-1:0] res; logic fw, re, dz, to; int lat;
        expected_dividend = 16'd12099;
        run_op(16'd123, 16'd98, 16'd45, res, fw, re, dz, lat, to);
        n_cmp++;
        if (to || match !== 1'b1) begin
            n_err++;
            $display("FAIL check_match got to=%b match=%b required 0 1", to, match);
        end
        expected_dividend = 16'd12100;
        run_op(16'd123, 16'd98, 16'd45, res, fw, re, dz, lat, to);
        n_cmp++;
        if (to || match !== 1'b0) begin
            n_err++;
            $display("FAIL check_nomatch got to=%b match=%b required 0 0", to, match);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_basic();
        test_max();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
`ifdef DHVAJANKA_RECON_CHECK_EN
        test_check();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
